// File: rtl/mcu_acc_core.sv
// Multicycle accumulator MCU (fetch/decode/mem/halt) with a req/ack memory port.
// Defining MCU_ACC_IRQ_EN adds the irq port, EPC/ESW registers, IE control and IRET.
module mcu_acc_core #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [AW-1:0] IRQ_VEC = AW'('h010)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
`ifdef MCU_ACC_IRQ_EN
  input  logic          irq,
`endif
  output logic          halted,
  output logic [AW-1:0] dbg_pc,
  output logic [DW-1:0] dbg_acc,
  output logic [3:0]    dbg_sw,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_MEM    = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam logic [3:0] OP_LD  = 4'h0, OP_ADD = 4'h1, OP_JMP = 4'h2, OP_ST   = 4'h3;
  localparam logic [3:0] OP_CMP = 4'h4, OP_JEQ = 4'h5, OP_SUB = 4'h6, OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8, OP_XOR = 4'h9, OP_JLT = 4'hA, OP_LDI  = 4'hB;
  localparam logic [3:0] OP_JNE = 4'hC, OP_HALT = 4'hF;
`ifdef MCU_ACC_IRQ_EN
  localparam logic [3:0] OP_IRET = 4'hE;
`endif

  logic [1:0]    state;
  logic [AW-1:0] pc, pc_inc, dec_pc, cfield;
  logic [DW-1:0] acc, ir, ldi_val, alu_res;
  logic [DW:0]   alu_wide;
  logic [3:0]    op;
  logic [2:0]    dec_nzc;
  logic          flag_n, flag_z, flag_c, flag_ie;
  logic          is_mem_op, alu_wr;
  logic          unused_bits;

`ifdef MCU_ACC_IRQ_EN
  logic [AW-1:0] epc;
  logic [2:0]    esw;
`else
  assign flag_ie = 1'b0;
`endif

  assign op        = ir[DW-1:DW-4];
  assign cfield    = ir[AW-1:0];
  assign pc_inc    = pc + AW'(1);
  assign ldi_val   = {{(DW-AW){1'b0}}, cfield};
  assign is_mem_op = op inside {OP_LD, OP_ADD, OP_ST, OP_CMP, OP_SUB, OP_AND, OP_OR, OP_XOR};
  assign unused_bits = ^{ir, IRQ_VEC};

  // Next PC and flags for the single-cycle (non-memory) instructions.
  always_comb begin
    dec_pc  = pc;
    dec_nzc = {flag_n, flag_z, flag_c};
    case (op)
      OP_JMP: dec_pc = cfield;
      OP_JEQ: if (flag_z) dec_pc = cfield;
      OP_JLT: if (flag_n) dec_pc = cfield;
      OP_JNE: if (!flag_z) dec_pc = cfield;
      OP_LDI: dec_nzc = {ldi_val[DW-1], ldi_val == '0, flag_c};
`ifdef MCU_ACC_IRQ_EN
      OP_IRET: begin
        dec_pc  = epc;
        dec_nzc = esw;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    alu_wide = '0;
    alu_res  = acc;
    alu_wr   = 1'b1;
    case (op)
      OP_LD:  alu_res = mem_rdata;
      OP_ADD: begin
        alu_wide = {1'b0, acc} + {1'b0, mem_rdata};
        alu_res  = alu_wide[DW-1:0];
      end
      OP_SUB: begin
        alu_wide = {1'b0, acc} - {1'b0, mem_rdata};
        alu_res  = alu_wide[DW-1:0];
      end
      OP_AND: alu_res = acc & mem_rdata;
      OP_OR:  alu_res = acc | mem_rdata;
      OP_XOR: alu_res = acc ^ mem_rdata;
      default: alu_wr = 1'b0;
    endcase
  end

  // Bus: mem_req high = request valid (we/addr/wdata held); mem_ack is the one-cycle ready.
  // The edge that sees mem_ack ends the access; req still high on the next cycle is a new access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      acc       <= '0;
      ir        <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
`ifdef MCU_ACC_IRQ_EN
      epc       <= '0;
      esw       <= '0;
      flag_ie   <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            ir      <= mem_rdata;
            pc      <= pc_inc;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_mem_op) begin
            mem_req  <= 1'b1;
            mem_we   <= (op == OP_ST);
            mem_addr <= cfield;
            if (op == OP_ST) mem_wdata <= acc;
            state    <= S_MEM;
          end else if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            if (op == OP_LDI) acc <= ldi_val;
            {flag_n, flag_z, flag_c} <= dec_nzc;
            pc       <= dec_pc;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= dec_pc;
            state    <= S_FETCH;
`ifdef MCU_ACC_IRQ_EN
            if (op == OP_IRET) flag_ie <= 1'b1;
            if (irq && flag_ie) begin
              epc      <= dec_pc;
              esw      <= dec_nzc;
              flag_ie  <= 1'b0;
              pc       <= IRQ_VEC;
              mem_addr <= IRQ_VEC;
            end
`endif
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (alu_wr) begin
              acc    <= alu_res;
              flag_n <= alu_res[DW-1];
              flag_z <= (alu_res == '0);
            end
            if (op == OP_ADD || op == OP_SUB) flag_c <= alu_wide[DW];
            if (op == OP_CMP) begin
              flag_n <= (acc < mem_rdata);
              flag_z <= (acc == mem_rdata);
            end
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            state    <= S_FETCH;
          end
        end
        S_HALT: begin
`ifdef MCU_ACC_IRQ_EN
          if (irq && flag_ie) begin
            epc      <= pc;
            esw      <= {flag_n, flag_z, flag_c};
            flag_ie  <= 1'b0;
            pc       <= IRQ_VEC;
            halted   <= 1'b0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= IRQ_VEC;
            state    <= S_FETCH;
          end
`endif
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign dbg_pc    = pc;
  assign dbg_acc   = acc;
  assign dbg_sw    = {flag_n, flag_z, flag_c, flag_ie};
  assign dbg_state = state;

endmodule
